uart_tx_fifo: RTL and testbench

- Buffered UART transmitter for the CPU's Tx pin. It is the transmit end of the serial link whose receive end is the host or simulation side.
- The memory/IO controller pushes bytes into an internal FIFO. An FSM serialises each byte as 8N1 (optionally 8E1), LSB first, at a fixed clocks-per-bit rate.
- It sits between the IO-mapped write path and the top-level Tx pin.

---
 rtl/uart_tx_fifo.sv | 190 +++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: byte FIFO feeding an 8N1 serialiser, LSB first.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop (8E1).
module uart_tx_fifo #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned ADDR_BITS    = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_en,
  input  logic [7:0]         wr_data,
  output logic               full,
  output logic [ADDR_BITS:0] count,
  output logic               overflow,
  output logic               busy,
  output logic               tx
);

  localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);
  localparam logic [ADDR_BITS:0] DepthCnt = {1'b1, {ADDR_BITS{1'b0}}};
  localparam logic [ADDR_BITS:0] CountOne = (ADDR_BITS + 1)'(1);
  localparam logic [ADDR_BITS-1:0] PtrOne = ADDR_BITS'(1);
  localparam logic [CntW-1:0] CntOne = CntW'(1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
`ifdef UART_TX_PARITY_EN
    StParity,
`endif
    StStop
  } state_e;

  state_e                 state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [2:0]             bit_q, bit_d;
  logic [7:0]             shift_q, shift_d;
  logic [ADDR_BITS-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_BITS-1:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_BITS:0]     count_q, count_d;
  logic                   full_q, full_d;
  logic                   overflow_q, overflow_d;
  logic                   busy_q, busy_d;
  logic                   tx_q, tx_d;
  logic                   push, pop, cnt_last;
  logic [7:0]             mem_q [2**ADDR_BITS];

  assign full     = full_q;
  assign count    = count_q;
  assign overflow = overflow_q;
  assign busy     = busy_q;
  assign tx       = tx_q;

  // Push is gated by the registered full flag, so a same-edge pop never admits a push.
  assign push     = wr_en && !full_q;
  assign cnt_last = (cnt_q == CntMax);

  // FIFO storage; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  // Serialiser next state, pop decision and bit timing.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          cnt_d   = '0;
          state_d = StStart;
        end
      end
      StStart: begin
        if (cnt_last) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = StData;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      StData: begin
        if (cnt_last) begin
          cnt_d = '0;
          if (bit_q == 3'd7) begin
            bit_d   = '0;
`ifdef UART_TX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
`ifdef UART_TX_PARITY_EN
      StParity: begin
        if (cnt_last) begin
          cnt_d   = '0;
          state_d = StStop;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
`endif
      StStop: begin
        if (cnt_last) begin
          cnt_d = '0;
          // Chain straight into the next start bit when data is waiting.
          if (count_q != '0) begin
            pop     = 1'b1;
            shift_d = mem_q[rd_ptr_q];
            state_d = StStart;
          end else begin
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FIFO bookkeeping and registered status outputs derived from next state.
  always_comb begin
    wr_ptr_d   = push ? wr_ptr_q + PtrOne : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + PtrOne : rd_ptr_q;
    count_d    = count_q;
    if (push && !pop) begin
      count_d = count_q + CountOne;
    end else if (pop && !push) begin
      count_d = count_q - CountOne;
    end
    full_d     = (count_d == DepthCnt);
    overflow_d = overflow_q || (wr_en && full_q);
    busy_d     = (state_d != StIdle);
    tx_d       = 1'b1;
    case (state_d)
      StStart:  tx_d = 1'b0;
      StData:   tx_d = shift_d[bit_d];
`ifdef UART_TX_PARITY_EN
      StParity: tx_d = ^shift_d;
`endif
      default:  tx_d = 1'b1;
    endcase
  end

  // State register; reset truncates any frame and discards queued bytes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      overflow_q <= 1'b0;
      busy_q     <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      overflow_q <= overflow_d;
      busy_q     <= busy_d;
      tx_q       <= tx_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: accepted bytes are queued as expected frames, an
// independent serial receiver decodes tx and compares against the queue.
module tb_uart_tx_fifo;

  localparam int unsigned CPB   = 4;
  localparam int unsigned AB    = 2;
  localparam int unsigned Depth = 4;
`ifdef UART_TX_PARITY_EN
  localparam int unsigned NBits = 11;
`else
  localparam int unsigned NBits = 10;
`endif
  localparam int unsigned FL = NBits * CPB;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_en;
  logic [7:0]    wr_data;
  logic          full;
  logic [AB:0]   count;
  logic          overflow;
  logic          busy;
  logic          tx;

  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  logic [7:0]    exp_q[$];
  int            starts_q[$];

  uart_tx_fifo #(
    .CLKS_PER_BIT(CPB),
    .ADDR_BITS   (AB)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .full    (full),
    .count   (count),
    .overflow(overflow),
    .busy    (busy),
    .tx      (tx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // accept: whether the FIFO has room for this byte at this edge.
  task automatic push(input logic [7:0] d, input bit accept);
    wr_en   = 1'b1;
    wr_data = d;
    if (accept) exp_q.push_back(d);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((busy || count != '0) && n < 20 * FL) begin
      tick();
      n++;
    end
    check(name, 32'(busy || count != '0), 0);
    repeat (2) tick();
    check({name, "_drained"}, exp_q.size(), 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    exp_q.delete();
    rst_n = 1'b1;
    tick();
  endtask

  // Serial receiver: samples every cycle, each bit must hold for exactly CPB samples.
  initial begin : monitor
    logic [NBits-1:0] bits;
    logic             stable;
    logic             aborted;
    logic [7:0]       b;
    forever begin
      @(negedge clk);
      if (rst_n && tx === 1'b0) begin
        starts_q.push_back(cyc);
        aborted = 1'b0;
        stable  = 1'b1;
        bits    = '0;
        for (int i = 0; i < NBits; i++) begin
          for (int s = 0; s < CPB; s++) begin
            if (!(i == 0 && s == 0)) @(negedge clk);
            if (!rst_n) begin
              aborted = 1'b1;
              break;
            end
            if (s == 0) bits[i] = tx;
            else if (tx !== bits[i]) stable = 1'b0;
          end
          if (aborted) break;
        end
        if (!aborted) begin
          b = bits[8:1];
          check("bit_timing", 32'(stable), 1);
          check("start_bit", 32'(bits[0]), 0);
`ifdef UART_TX_PARITY_EN
          check("parity_bit", 32'(bits[9]), 32'(^b));
`endif
          check("stop_bit", 32'(bits[NBits-1]), 1);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_frame: got %02h expected none", b);
          end else begin
            check("frame_data", b, exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin : watchdog
    #(200000 * 10);
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin : stim
    int n;
    wr_en   = 1'b0;
    wr_data = '0;
    rst_n   = 1'b0;
    repeat (3) tick();
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_count", count, 0);
    check("rst_full", full, 0);
    check("rst_overflow", overflow, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      check("idle_tx", tx, 1);
      check("idle_busy", busy, 0);
      check("idle_count", count, 0);
    end

    // Single byte: pop one edge after the push, busy for exactly one frame.
    push(8'hA5, 1'b1);
    check("a5_busy_pre", busy, 0);
    check("a5_tx_pre", tx, 1);
    check("a5_count_pre", count, 1);
    tick();
    check("a5_busy_pop", busy, 1);
    check("a5_tx_start", tx, 0);
    check("a5_count_pop", count, 0);
    repeat (FL - 1) tick();
    check("a5_busy_last", busy, 1);
    tick();
    check("a5_busy_end", busy, 0);
    check("a5_tx_end", tx, 1);
    wait_idle("a5_idle");

    // Three consecutive pushes: first pops immediately, the other two queue.
    starts_q.delete();
    push(8'h01, 1'b1);
    push(8'h80, 1'b1);
    push(8'hFF, 1'b1);
    check("b2b_count", count, 2);
    wait_idle("b2b_idle");
    check("b2b_frames", starts_q.size(), 3);
    if (starts_q.size() == 3) begin
      check("b2b_gap1", starts_q[1] - starts_q[0], FL);
      check("b2b_gap2", starts_q[2] - starts_q[1], FL);
    end

    // Random short bursts; never more than three outstanding, so all are accepted.
    for (int k = 0; k < 8; k++) begin
      n = int'($urandom_range(1, 3));
      for (int j = 0; j < n; j++) begin
        repeat ($urandom_range(0, 2)) tick();
        push(8'($urandom), 1'b1);
      end
      wait_idle("rand_idle");
    end
    check("rand_overflow", overflow, 0);

    // Overflow: with one frame in flight no pop happens for FL cycles, so only
    // Depth of the six pushes fit.
    push(8'h11, 1'b1);
    tick();
    tick();
    check("ovf_busy", busy, 1);
    for (int i = 0; i < 6; i++) push(8'(8'h20 + i), i < Depth);
    check("ovf_full", full, 1);
    check("ovf_count", count, Depth);
    check("ovf_flag", overflow, 1);
    wait_idle("ovf_idle");
    check("ovf_sticky", overflow, 1);
    check("ovf_full_clear", full, 0);

    do_reset();
    check("rst2_overflow", overflow, 0);

    // Fill, then push while full on the exact edge where the stop bit ends and a pop occurs.
    push(8'h31, 1'b1);
    for (int i = 0; i < 4; i++) push(8'(8'h40 + i), 1'b1);
    check("fp_full", full, 1);
    check("fp_count", count, 4);
    check("fp_overflow_pre", overflow, 0);
    repeat (FL - 4) tick();
    check("fp_count_before", count, 4);
    push(8'hEE, 1'b0);
    check("fp_count_after", count, 3);
    check("fp_full_after", full, 0);
    check("fp_overflow", overflow, 1);
    wait_idle("fp_idle");

    // Reset in the middle of data bit 3 with two bytes queued.
    push(8'h5A, 1'b1);
    push(8'h66, 1'b1);
    push(8'h77, 1'b1);
    repeat (16) tick();
    check("mr_busy_pre", busy, 1);
    rst_n = 1'b0;
    #1;
    check("mr_tx", tx, 1);
    check("mr_count", count, 0);
    check("mr_busy", busy, 0);
    check("mr_full", full, 0);
    exp_q.delete();
    repeat (3) tick();
    rst_n = 1'b1;
    for (int i = 0; i < 200; i++) begin
      tick();
      check("mr_quiet_tx", tx, 1);
      check("mr_quiet_busy", busy, 0);
    end
    check("final_queue", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
